instr_encoder: RTL and testbench
================================

# instr_encoder

Command-to-machine-code encoder that sits in front of the processor's instruction memory. It is the encode side of the instruction format that `Control_Unit` decodes. It accepts one decoded command per valid/ready handshake (from the command-line front end) and builds the 32-bit ARM word for that subset: AND/SUB/ADD/ORR/CMP, LDR/STR, B. It writes each word to consecutive instruction-memory word addresses and flags illegal immediates and a full program buffer.

## Interface
- `ADDR_W`, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W.
- `CLK`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous program clear; priority over everything except `reset`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  = (state==IDLE) & ~clear.
- `cmd_op`  in  3  0 AND, 1 SUB, 2 ADD, 3 ORR, 4 CMP, 5 LDR, 6 STR, 7 B.
- `cmd_cond`  in  4  condition field, copied to [31:28].
- `cmd_s`  in  1  S bit for AND/SUB/ADD/ORR (CMP forces 1; ignored for LDR/STR/B).
- `cmd_imm_en`  in  1  1 = immediate second operand/offset, 0 = register Rm.
- `cmd_rd`, `cmd_rn`, `cmd_rm`  in  4 each  register numbers.
- `cmd_imm`  in  24  immediate / branch offset (word units, two's complement for B).
- `IMemWE`  out  1  instruction-memory write enable, one cycle per word.
- `IMemAddr`  out  ADDR_W  word write address.
- `IMemWD`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  words written since reset/clear.
- `full`  out  1  DEPTH words written.
- `err`  out  1  sticky illegal-command flag.

## Operation
- States: IDLE, ENCODE, WRITE, FULL.
- IDLE: on `cmd_valid & cmd_ready`, latch all `cmd_*` fields and go to ENCODE.
- ENCODE, one cycle: build the word into the `IMemWD` register and run the legality check.
  - Legal: go to WRITE.
  - Illegal: set `err`, go to IDLE. No write; address unchanged.
- WRITE: `IMemWE`=1 for exactly this cycle. On exit, `IMemAddr`+1 and `count`+1.
  - If the written address was DEPTH-1: go to FULL. `IMemAddr` wraps to 0.
  - Otherwise: go to IDLE.
- FULL: `full`=1, `cmd_ready`=0. Leave only on `clear` or `reset`.
- `clear`, in any state:
  - Go to IDLE; `IMemAddr`=0, `count`=0, `err`=0, `full`=0.
  - An in-flight command is dropped and `IMemWE` is not asserted.
- Encoding:
  - Data processing: [27:26]=00, [25]=`cmd_imm_en`, [24:21]: AND 0000, SUB 0010, ADD 0100, ORR 1100, CMP 1010.
  - [20]=S, [19:16]=Rn, [15:12]=Rd (CMP: Rd=0). [11:0]: imm form = {4'b0 rot, imm[7:0]}; register form = {8'b0, Rm}.
  - Memory: [27:26]=01, [25]=~`cmd_imm_en`, [24:21]=1100 (P=1, U=1, B=0, W=0), [20]=1 for LDR, 0 for STR.
  - Memory [19:16]=Rn (base), [15:12]=Rd. [11:0] = imm[11:0] or {8'b0, Rm}.
  - Branch: [27:24]=1010, [23:0]=`cmd_imm`. Register fields ignored.
- Legality:
  - Data-processing immediate requires imm[23:8]==0.
  - Memory immediate requires imm[23:12]==0.
  - Branch is always legal.
  - B with `cmd_imm_en`=0 is legal (the flag is ignored).

## Timing
- Reset values:
  - State IDLE, so `cmd_ready`=1 while `reset` is low.
  - `IMemWE`=0, `IMemAddr`=0, `IMemWD`=0, `count`=0, `full`=0, `err`=0.
- Asserting `reset` mid-WRITE drops `IMemWE` immediately (asynchronously).
- Latency: handshake at edge N; `IMemWD` valid and `IMemWE`=1 during cycle N+1..N+2; memory write on edge N+2.
- Illegal command: `err` rises after edge N+1; `cmd_ready` high again in the cycle after edge N+1.
- Throughput: one legal command per 3 cycles.
- `cmd_valid` with `cmd_ready`=0: the command is not consumed and may be held indefinitely.
- `clear` coincident with `cmd_valid`: the command is not accepted.
- `IMemWD` holds its last value outside WRITE.

## Test plan
- ADD r1,r2,#5, cond E, S=0 -> `IMemWE` pulse at addr 0, `IMemWD`=0xE2821005, `count`=1.
- SUB r3,r4,r5 (register), then CMP r2,#0 -> 0xE0443005 at addr 0, 0xE3520000 at addr 1 (S forced).
- LDR r0,[r1,#8] -> 0xE5910008; STR r0,[r1,#8] -> 0xE5810008; B cond E, imm 0xFFFFFE -> 0xEAFFFFFE.
- ADD imm 0x100 -> `err`=1, no `IMemWE`, `IMemAddr` unchanged, `cmd_ready` back 2 cycles after handshake.
- ADDR_W=2, four legal commands -> `full`=1, `count`=4, `cmd_ready`=0. Fifth `cmd_valid` held is not accepted. `clear` -> `count`=0, `IMemAddr`=0, next command lands at addr 0.
- `reset` low during WRITE -> `IMemWE` 0 immediately, all outputs at reset values. After release, the first command writes addr 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes one decoded command per handshake into a 32-bit ARM word and writes it
// to consecutive instruction-memory addresses, flagging illegal immediates.
module instr_encoder #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [3:0]        cmd_cond,
    input  logic              cmd_s,
    input  logic              cmd_imm_en,
    input  logic [3:0]        cmd_rd,
    input  logic [3:0]        cmd_rn,
    input  logic [3:0]        cmd_rm,
    input  logic [23:0]       cmd_imm,
    output logic              IMemWE,
    output logic [ADDR_W-1:0] IMemAddr,
    output logic [31:0]       IMemWD,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        WRITE  = 2'd2,
        FULL   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_SUB = 3'd1,
        OP_ADD = 3'd2,
        OP_ORR = 3'd3,
        OP_CMP = 3'd4,
        OP_LDR = 3'd5,
        OP_STR = 3'd6,
        OP_B   = 3'd7
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [3:0]  cond;
        logic        s;
        logic        imm_en;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm;
    } cmd_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   COUNT_ONE = 1;

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [31:0]         wd_q, wd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic [3:0]          dp_opcode;
    logic                dp_s;
    logic [3:0]          dp_rd;
    logic [11:0]         dp_op2;
    logic [11:0]         mem_off;

    // Instruction word built from the latched command
    always_comb begin
        dp_opcode = 4'b0000;
        dp_s      = cmd_q.s;
        dp_rd     = cmd_q.rd;
        dp_op2    = cmd_q.imm_en ? {4'b0000, cmd_q.imm[7:0]} : {8'h00, cmd_q.rm};
        mem_off   = cmd_q.imm_en ? cmd_q.imm[11:0] : {8'h00, cmd_q.rm};
        enc_word  = '0;
        enc_legal = 1'b1;

        unique case (cmd_q.op)
            OP_AND: dp_opcode = 4'b0000;
            OP_SUB: dp_opcode = 4'b0010;
            OP_ADD: dp_opcode = 4'b0100;
            OP_ORR: dp_opcode = 4'b1100;
            OP_CMP: begin
                dp_opcode = 4'b1010;
                dp_s      = 1'b1;
                dp_rd     = 4'b0000;
            end
            default: dp_opcode = 4'b0000;
        endcase

        unique case (cmd_q.op)
            OP_LDR, OP_STR: begin
                enc_word  = {cmd_q.cond, 2'b01, ~cmd_q.imm_en, 4'b1100,
                             (cmd_q.op == OP_LDR), cmd_q.rn, cmd_q.rd, mem_off};
                enc_legal = ~cmd_q.imm_en | (cmd_q.imm[23:12] == '0);
            end
            OP_B: begin
                enc_word  = {cmd_q.cond, 4'b1010, cmd_q.imm};
                enc_legal = 1'b1;
            end
            default: begin
                enc_word  = {cmd_q.cond, 2'b00, cmd_q.imm_en, dp_opcode,
                             dp_s, cmd_q.rn, dp_rd, dp_op2};
                enc_legal = ~cmd_q.imm_en | (cmd_q.imm[23:8] == '0);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wd_d    = wd_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;

        if (clear) begin
            state_d = IDLE;
            addr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_d = '{op: op_t'(cmd_op), cond: cmd_cond, s: cmd_s,
                                  imm_en: cmd_imm_en, rd: cmd_rd, rn: cmd_rn,
                                  rm: cmd_rm, imm: cmd_imm};
                        state_d = ENCODE;
                    end
                end
                ENCODE: begin
                    if (enc_legal) begin
                        wd_d    = enc_word;
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    addr_d  = addr_q + ADDR_ONE;
                    count_d = count_q + COUNT_ONE;
                    state_d = (addr_q == '1) ? FULL : IDLE;
                end
                FULL: state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            wd_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wd_q    <= wd_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // A clear landing in WRITE cancels the pending memory write
    assign IMemWE    = (state_q == WRITE) & ~clear;
    assign cmd_ready = (state_q == IDLE) & ~clear;
    assign full      = (state_q == FULL);
    assign IMemAddr  = addr_q;
    assign IMemWD    = wd_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: default-depth instance plus a 4-word
// instance used for the full/clear scenario.
module tb_instr_encoder;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  cond;
        logic        s;
        logic        imm_en;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm;
    } cmd_t;

    logic        CLK = 1'b0;
    logic        reset, clear, cmd_valid, cmd_valid_s;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_cond, cmd_rd, cmd_rn, cmd_rm;
    logic        cmd_s, cmd_imm_en;
    logic [23:0] cmd_imm;

    logic        ready, we, full, err;
    logic [5:0]  addr;
    logic [31:0] wd;
    logic [6:0]  count;

    logic        ready_s, we_s, full_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wd_s;
    logic [2:0]  count_s;

    int checks, failures;
    int wr_cnt, wr_cnt_s;
    int unsigned mdl_addr;
    logic [31:0] exp_wd_q[$];
    logic [5:0]  exp_addr_q[$];

    instr_encoder #(.ADDR_W(6)) u_dut (
        .CLK(CLK), .reset(reset), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(ready),
        .cmd_op(cmd_op), .cmd_cond(cmd_cond), .cmd_s(cmd_s), .cmd_imm_en(cmd_imm_en),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
        .IMemWE(we), .IMemAddr(addr), .IMemWD(wd), .count(count), .full(full), .err(err)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .CLK(CLK), .reset(reset), .clear(clear), .cmd_valid(cmd_valid_s), .cmd_ready(ready_s),
        .cmd_op(cmd_op), .cmd_cond(cmd_cond), .cmd_s(cmd_s), .cmd_imm_en(cmd_imm_en),
        .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_imm(cmd_imm),
        .IMemWE(we_s), .IMemAddr(addr_s), .IMemWD(wd_s), .count(count_s), .full(full_s),
        .err(err_s)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (we)   wr_cnt++;
        if (we_s) wr_cnt_s++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input bit sm, input cmd_t c, output bit ok);
        ok = 1'b0;
        @(negedge CLK);
        {cmd_op, cmd_cond, cmd_s, cmd_imm_en, cmd_rd, cmd_rn, cmd_rm, cmd_imm} = c;
        if (sm) cmd_valid_s = 1'b1; else cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sm ? ready_s : ready) begin
                @(posedge CLK);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        cmd_valid   = 1'b0;
        cmd_valid_s = 1'b0;
    endtask

    task automatic wait_we(input bit sm, output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (sm ? we_s : we) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        mdl_addr = 0;
    endtask

    task automatic test_reset();
        #12;
        checks += 7;
        if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
        if (we !== 1'b0)    begin failures++; $display("FAIL rst_we got=%b exp=0", we); end
        if (addr !== 6'd0)  begin failures++; $display("FAIL rst_addr got=%0d exp=0", addr); end
        if (wd !== 32'd0)   begin failures++; $display("FAIL rst_wd got=%h exp=0", wd); end
        if (count !== 7'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        if (full !== 1'b0)  begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
        if (err !== 1'b0)   begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        @(negedge CLK);
        reset = 1'b1;
        mdl_addr = 0;
    endtask

    // Runs a table of legal commands against the default instance via the scoreboard
    task automatic run_table(input string name, input cmd_t tbl[$], input logic [31:0] exp[$]);
        bit ok, got;
        logic [31:0] ed;
        logic [5:0]  ea;
        foreach (tbl[i]) begin
            exp_wd_q.push_back(exp[i]);
            exp_addr_q.push_back(6'(mdl_addr));
            mdl_addr++;
            send(1'b0, tbl[i], ok);
            wait_we(1'b0, got);
            ed = exp_wd_q.pop_front();
            ea = exp_addr_q.pop_front();
            checks++;
            if (!ok || !got) begin
                failures++;
                $display("FAIL %s_we[%0d] got=ok%0b/we%0b exp=handshake+write", name, i, ok, got);
            end else begin
                checks += 2;
                if (wd !== ed) begin
                    failures++; $display("FAIL %s_wd[%0d] got=%h exp=%h", name, i, wd, ed);
                end
                if (addr !== ea) begin
                    failures++; $display("FAIL %s_addr[%0d] got=%0d exp=%0d", name, i, addr, ea);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_add();
        cmd_t t[$];
        logic [31:0] e[$];
        t.push_back('{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'd5}); e.push_back(32'hE2821005);
        run_table("add", t, e);
        checks += 2;
        if (count !== 7'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", count); end
        if (addr !== 6'd1)  begin failures++; $display("FAIL add_addr_next got=%0d exp=1", addr); end
    endtask

    task automatic test_sub_cmp();
        cmd_t t[$];
        logic [31:0] e[$];
        pulse_clear();
        t.push_back('{3'd1, 4'hE, 1'b0, 1'b0, 4'd3, 4'd4, 4'd5, 24'd0}); e.push_back(32'hE0443005);
        t.push_back('{3'd4, 4'hE, 1'b0, 1'b1, 4'd9, 4'd2, 4'd0, 24'd0}); e.push_back(32'hE3520000);
        run_table("subcmp", t, e);
        checks++;
        if (count !== 7'd2) begin failures++; $display("FAIL subcmp_count got=%0d exp=2", count); end
    endtask

    task automatic test_ldst_branch();
        cmd_t t[$];
        logic [31:0] e[$];
        t.push_back('{3'd5, 4'hE, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'd8});    e.push_back(32'hE5910008);
        t.push_back('{3'd6, 4'hE, 1'b1, 1'b1, 4'd0, 4'd1, 4'd0, 24'd8});    e.push_back(32'hE5810008);
        t.push_back('{3'd7, 4'hE, 1'b0, 1'b1, 4'd7, 4'd7, 4'd7, 24'hFFFFFE}); e.push_back(32'hEAFFFFFE);
        t.push_back('{3'd5, 4'h0, 1'b0, 1'b0, 4'd6, 4'd7, 4'd8, 24'd0});    e.push_back(32'h07976008);
        t.push_back('{3'd3, 4'h1, 1'b1, 1'b1, 4'd10, 4'd11, 4'd0, 24'h3C}); e.push_back(32'h139BA03C);
        t.push_back('{3'd0, 4'hA, 1'b0, 1'b0, 4'd15, 4'd14, 4'd13, 24'd0}); e.push_back(32'hA00EF00D);
        run_table("ldstb", t, e);
    endtask

    task automatic test_boundary();
        cmd_t t[$];
        logic [31:0] e[$];
        t.push_back('{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'hFF});     e.push_back(32'hE28210FF);
        t.push_back('{3'd5, 4'hE, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'hFFF});    e.push_back(32'hE5910FFF);
        t.push_back('{3'd7, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h10});     e.push_back(32'h0A000010);
        t.push_back('{3'd1, 4'hE, 1'b0, 1'b0, 4'd3, 4'd4, 4'd5, 24'hFFFFFF}); e.push_back(32'hE0443005);
        run_table("bound", t, e);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL bound_err got=%b exp=0", err); end
    endtask

    task automatic test_illegal();
        bit ok;
        int wc;
        pulse_clear();
        wc = wr_cnt;
        send(1'b0, '{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'h100}, ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL ill_hs got=none exp=handshake"); end
        if (ready !== 1'b0) begin failures++; $display("FAIL ill_ready_enc got=%b exp=0", ready); end
        @(posedge CLK);
        @(negedge CLK);
        checks += 2;
        if (err !== 1'b1)   begin failures++; $display("FAIL ill_err got=%b exp=1", err); end
        if (ready !== 1'b1) begin failures++; $display("FAIL ill_ready_back got=%b exp=1", ready); end
        repeat (3) @(negedge CLK);
        checks += 3;
        if (wr_cnt !== wc)  begin failures++; $display("FAIL ill_we got=%0d exp=%0d", wr_cnt, wc); end
        if (addr !== 6'd0)  begin failures++; $display("FAIL ill_addr got=%0d exp=0", addr); end
        if (count !== 7'd0) begin failures++; $display("FAIL ill_count got=%0d exp=0", count); end

        pulse_clear();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", err); end
        send(1'b0, '{3'd6, 4'hE, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'h1000}, ok);
        repeat (4) @(negedge CLK);
        checks += 2;
        if (err !== 1'b1)  begin failures++; $display("FAIL ill_mem_err got=%b exp=1", err); end
        if (wr_cnt !== wc) begin failures++; $display("FAIL ill_mem_we got=%0d exp=%0d", wr_cnt, wc); end
        pulse_clear();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        cmd_t t[$];
        logic [31:0] e[$];
        send(1'b0, '{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'd6}, ok);
        @(posedge CLK);
        #1;
        checks++;
        if (we !== 1'b1) begin failures++; $display("FAIL rmw_we_pre got=%b exp=1", we); end
        reset = 1'b0;
        #1;
        checks += 6;
        if (we !== 1'b0)    begin failures++; $display("FAIL rmw_we got=%b exp=0", we); end
        if (addr !== 6'd0)  begin failures++; $display("FAIL rmw_addr got=%0d exp=0", addr); end
        if (wd !== 32'd0)   begin failures++; $display("FAIL rmw_wd got=%h exp=0", wd); end
        if (count !== 7'd0) begin failures++; $display("FAIL rmw_count got=%0d exp=0", count); end
        if (ready !== 1'b1) begin failures++; $display("FAIL rmw_ready got=%b exp=1", ready); end
        if (err !== 1'b0)   begin failures++; $display("FAIL rmw_err got=%b exp=0", err); end
        @(negedge CLK);
        reset = 1'b1;
        mdl_addr = 0;
        t.push_back('{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'd7}); e.push_back(32'hE2821007);
        run_table("rmw_after", t, e);
    endtask

    task automatic test_full();
        bit ok, got;
        int wc;
        logic [31:0] ed;
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            exp_wd_q.push_back(32'hE2821000 | 32'(i));
            exp_addr_q.push_back(6'(i));
            send(1'b1, '{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'(i)}, ok);
            wait_we(1'b1, got);
            ed = exp_wd_q.pop_front();
            checks++;
            if (!ok || !got) begin
                failures++; $display("FAIL full_we[%0d] got=ok%0b/we%0b exp=handshake+write", i, ok, got);
                void'(exp_addr_q.pop_front());
            end else begin
                checks += 2;
                if (wd_s !== ed) begin
                    failures++; $display("FAIL full_wd[%0d] got=%h exp=%h", i, wd_s, ed);
                end
                if (addr_s !== exp_addr_q[0][1:0]) begin
                    failures++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, addr_s, exp_addr_q[0]);
                end
                void'(exp_addr_q.pop_front());
            end
            @(posedge CLK);
            #1;
        end
        checks += 4;
        if (full_s !== 1'b1)  begin failures++; $display("FAIL full_flag got=%b exp=1", full_s); end
        if (count_s !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count_s); end
        if (ready_s !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ready_s); end
        if (addr_s !== 2'd0)  begin failures++; $display("FAIL full_addr_wrap got=%0d exp=0", addr_s); end

        wc = wr_cnt_s;
        @(negedge CLK);
        cmd_valid_s = 1'b1;
        repeat (6) @(negedge CLK);
        checks += 3;
        if (count_s !== 3'd4) begin failures++; $display("FAIL held_count got=%0d exp=4", count_s); end
        if (wr_cnt_s !== wc)  begin failures++; $display("FAIL held_we got=%0d exp=%0d", wr_cnt_s, wc); end
        if (full_s !== 1'b1)  begin failures++; $display("FAIL held_full got=%b exp=1", full_s); end

        clear = 1'b1;
        @(posedge CLK);
        #1;
        clear = 1'b0;
        cmd_valid_s = 1'b0;
        checks += 3;
        if (count_s !== 3'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", count_s); end
        if (addr_s !== 2'd0)  begin failures++; $display("FAIL clr_addr got=%0d exp=0", addr_s); end
        if (full_s !== 1'b0)  begin failures++; $display("FAIL clr_full got=%b exp=0", full_s); end

        // clear coincident with a command in IDLE: the command must be dropped
        @(negedge CLK);
        clear = 1'b1;
        cmd_valid_s = 1'b1;
        #1;
        checks++;
        if (ready_s !== 1'b0) begin failures++; $display("FAIL clrv_ready got=%b exp=0", ready_s); end
        @(posedge CLK);
        #1;
        clear = 1'b0;
        cmd_valid_s = 1'b0;
        repeat (4) @(negedge CLK);
        checks += 2;
        if (wr_cnt_s !== wc)  begin failures++; $display("FAIL clrv_we got=%0d exp=%0d", wr_cnt_s, wc); end
        if (count_s !== 3'd0) begin failures++; $display("FAIL clrv_count got=%0d exp=0", count_s); end

        send(1'b1, '{3'd2, 4'hE, 1'b0, 1'b1, 4'd1, 4'd2, 4'd0, 24'd9}, ok);
        wait_we(1'b1, got);
        checks++;
        if (!ok || !got) begin
            failures++; $display("FAIL after_clr_we got=ok%0b/we%0b exp=handshake+write", ok, got);
        end else begin
            checks += 2;
            if (addr_s !== 2'd0)        begin failures++; $display("FAIL after_clr_addr got=%0d exp=0", addr_s); end
            if (wd_s !== 32'hE2821009) begin failures++; $display("FAIL after_clr_wd got=%h exp=e2821009", wd_s); end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; wr_cnt = 0; wr_cnt_s = 0; mdl_addr = 0;
        reset = 1'b0; clear = 1'b0; cmd_valid = 1'b0; cmd_valid_s = 1'b0;
        cmd_op = '0; cmd_cond = '0; cmd_s = 1'b0; cmd_imm_en = 1'b0;
        cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
        test_reset();
        test_add();
        test_sub_cmp();
        test_ldst_branch();
        test_boundary();
        test_illegal();
        test_reset_mid_write();
        test_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
